// File: rtl/dds_sine_core.sv
// Single-channel DDS: 32-bit phase accumulator feeding a quarter-wave sine ROM.
// Phase -> address register -> registered table read gives a 2-clock phase-to-sample lag.
module dds_sine_core (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] freq,
  input  logic [31:0] freq_add,
  output logic [15:0] dac_signal,
  output logic [31:0] phase
);

  localparam int QTAB_N = 257;
  localparam int QTAB_W = QTAB_N * 16;
  localparam logic signed [127:0] PI_Q60 = 128'sh3243F6A8885A308D;

  // Builds trunc(32767*sin(pi*k/512)) for k = 0..256 with Q60 Taylor series;
  // results within 2^-30 below an integer are rounded up so sin(pi/2) lands on 32767.
  function automatic logic [QTAB_W-1:0] build_qtab();
    logic [QTAB_W-1:0]   tab;
    logic signed [127:0] x;
    logic signed [127:0] x2;
    logic signed [127:0] term;
    logic signed [127:0] sum;
    logic signed [127:0] prod;
    logic signed [127:0] val;
    tab = '0;
    for (int k = 0; k < QTAB_N; k++) begin
      x    = $signed((128'(k) * PI_Q60) >> 9);
      x2   = (x * x) >>> 60;
      term = x;
      sum  = x;
      for (int n = 1; n <= 14; n++) begin
        term = -((term * x2) >>> 60);
        term = term / $signed(128'(2 * n * (2 * n + 1)));
        sum  = sum + term;
      end
      prod = sum * 128'sd32767;
      val  = prod >>> 60;
      if (prod[59:0] > 60'hFFF_FFFF_C000_0000) begin
        val = val + 128'sd1;
      end
      tab[k*16 +: 16] = val[15:0];
    end
    return tab;
  endfunction

  localparam logic [QTAB_W-1:0] QTAB = build_qtab();

  logic [31:0] step;
  logic [9:0]  addr;
  logic [8:0]  qtab_idx;
  logic [15:0] qtab_mag;
  logic [15:0] sin_val;

  assign step = freq + freq_add;

  // Odd quadrants read the quarter table backwards; the second half-wave is negated.
  always_comb begin
    qtab_idx = addr[8] ? (9'd256 - {1'b0, addr[7:0]}) : {1'b0, addr[7:0]};
    qtab_mag = QTAB[{qtab_idx, 4'b0000} +: 16];
    sin_val  = addr[9] ? (16'd0 - qtab_mag) : qtab_mag;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase      <= 32'h0000_0000;
      addr       <= 10'd0;
      dac_signal <= 16'h0000;
    end else begin
      phase      <= phase + step;
      addr       <= phase[31:22];
      dac_signal <= sin_val;
    end
  end

endmodule

// File: tb/tb_dds_sine_core.sv
// Directed testbench for dds_sine_core: vector table plus reset-mid-run and full-table sweep.
module tb_dds_sine_core;

  localparam real PI = 3.14159265358979323846;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] freq;
  logic [31:0] freq_add;
  logic [15:0] dac_signal;
  logic [31:0] phase;

  int checks = 0;
  int passed = 0;

  typedef struct {
    string       name;
    logic        rst;
    logic [31:0] f;
    logic [31:0] fa;
    logic [31:0] exp_phase;
    logic [15:0] exp_dac;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  dds_sine_core dut (
    .clk        (clk),
    .reset      (reset),
    .freq       (freq),
    .freq_add   (freq_add),
    .dac_signal (dac_signal),
    .phase      (phase)
  );

  function automatic logic [15:0] sin_ref(input int k);
    real v;
    v = 32767.0 * $sin(2.0 * PI * real'(k) / 1024.0);
    return 16'($rtoi(v));
  endfunction

  task automatic add_vec(input string name, input logic r, input logic [31:0] f, input logic [31:0] fa,
                         input logic [31:0] ep, input logic [15:0] ed);
    vec_t v;
    v.name = name; v.rst = r; v.f = f; v.fa = fa; v.exp_phase = ep; v.exp_dac = ed;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] f, input logic [31:0] fa);
    reset    = r;
    freq     = f;
    freq_add = fa;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] exp_phase, input logic [15:0] exp_dac);
    checks++;
    if (phase === exp_phase) passed++;
    else $display("[TB] FAIL %s phase: got %08h expected %08h", name, phase, exp_phase);
    checks++;
    if (dac_signal === exp_dac) passed++;
    else $display("[TB] FAIL %s dac: got %04h expected %04h", name, dac_signal, exp_dac);
  endtask

  logic [31:0] c2_phase [5];
  logic [15:0] c2_dac   [5];

  initial begin
    c2_phase = '{32'h0147AEB8, 32'h028F5D70, 32'h03D70C28, 32'h051EBAE0, 32'h06666998};
    c2_dac   = '{16'h0000, 16'h0000, 16'h03ED, 16'h07D9, 16'h0BC3};

    add_vec("reset0", 1'b1, 32'h0147AEB8, 32'h0, 32'h0, 16'h0);
    for (int i = 0; i < 5; i++)
      add_vec($sformatf("mhz_e%0d", i + 1), 1'b0, 32'h0147AEB8, 32'h0, c2_phase[i], c2_dac[i]);

    add_vec("quad_rst", 1'b1, 32'h40000000, 32'h0, 32'h0, 16'h0);
    add_vec("quad_e1", 1'b0, 32'h40000000, 32'h0, 32'h40000000, 16'h0000);
    add_vec("quad_e2", 1'b0, 32'h40000000, 32'h0, 32'h80000000, 16'h0000);
    add_vec("quad_e3", 1'b0, 32'h40000000, 32'h0, 32'hC0000000, 16'h7FFF);
    add_vec("quad_e4", 1'b0, 32'h40000000, 32'h0, 32'h00000000, 16'h0000);
    add_vec("quad_e5", 1'b0, 32'h40000000, 32'h0, 32'h40000000, 16'h8001);
    add_vec("quad_e6", 1'b0, 32'h40000000, 32'h0, 32'h80000000, 16'h0000);
    add_vec("quad_e7", 1'b0, 32'h40000000, 32'h0, 32'hC0000000, 16'h7FFF);

    add_vec("zero_rst", 1'b1, 32'h0147AEB8, 32'hFEB85148, 32'h0, 16'h0);
    add_vec("zero_e1", 1'b0, 32'h0147AEB8, 32'hFEB85148, 32'h0, 16'h0);
    add_vec("zero_e2", 1'b0, 32'h0147AEB8, 32'hFEB85148, 32'h0, 16'h0);
    add_vec("zero_e3", 1'b0, 32'h0147AEB8, 32'hFEB85148, 32'h0, 16'h0);
    add_vec("dbl_e1", 1'b0, 32'h0147AEB8, 32'h0147AEB8, 32'h028F5D70, 16'h0000);
    add_vec("dbl_e2", 1'b0, 32'h0147AEB8, 32'h0147AEB8, 32'h051EBAE0, 16'h0000);
    add_vec("dbl_e3", 1'b0, 32'h0147AEB8, 32'h0147AEB8, 32'h07AE1850, 16'h07D9);

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].rst, vecs[i].f, vecs[i].fa);
      checkOutput(vecs[i].name, vecs[i].exp_phase, vecs[i].exp_dac);
    end

    // Reset in the middle of a running tone, then the start-up sequence must repeat.
    applyStimulus(1'b1, 32'h0147AEB8, 32'h0);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, 32'h0147AEB8, 32'h0);
    applyStimulus(1'b1, 32'h0147AEB8, 32'h0);
    checkOutput("midrst", 32'h0, 16'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0147AEB8, 32'h0);
      checkOutput($sformatf("rerun_e%0d", i + 1), c2_phase[i], c2_dac[i]);
    end

    // One table address per clock walks the whole sine table.
    applyStimulus(1'b1, 32'h00400000, 32'h0);
    checkOutput("sweep_rst", 32'h0, 16'h0);
    for (int n = 1; n <= 1025; n++) begin
      applyStimulus(1'b0, 32'h00400000, 32'h0);
      checkOutput($sformatf("sweep_e%0d", n), 32'(n) << 22, (n >= 2) ? sin_ref(n - 2) : 16'h0000);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/dds_sine_core.md
Name: dds_sine_core

Overview:
Single-channel direct digital synthesizer (DDS).
- A 32-bit phase accumulator advances each clock by a tuning word: base frequency plus a signed offset.
- The top 10 phase bits address a 1024-entry, 16-bit sine table.
- The table output drives a DAC sample bus.
- The block sits between the frequency-control logic, which supplies freq and freq_add, and the DAC interface. The current phase is exported for phase-measurement logic.

Parameters:
None. Widths are fixed: phase 32 bits, table address 10 bits, sample 16 bits.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset, sampled on the rising edge of clk.
- freq  in  32  unsigned base tuning word = Fout[Hz]·2^32/Fclk.
- freq_add  in  32  signed (two's complement) tuning-word offset added to freq.
- dac_signal  out  16  two's-complement sine sample to the DAC, registered.
- phase  out  32  current phase-accumulator value, registered.

Behaviour:
- Clock/reset: one clock domain. reset is synchronous and active-high. No asynchronous paths.
- Reset: on a rising edge with reset=1:
  - phase = 0x00000000
  - internal table address register = 0
  - dac_signal = 0x0000
  - any internal table-output register = 0
- Reset has priority over all other updates. It may be asserted at any time, including mid-operation, and takes effect at the next edge.
- Tuning word: step = (freq + freq_add) mod 2^32. freq_add is sign-interpreted; the add wraps with no saturation. Inputs are combinational into the adder and are used on the same edge; no input registering.
- Accumulator: each non-reset edge, phase <= (phase + step) mod 2^32. The wrap from 0xFFFFFFFF to 0 is natural and has no side effects.
- Address stage: each non-reset edge, addr <= phase[31:22], using the pre-update phase value.
- Sine table: SIN[k] = trunc(32767·sin(2πk/1024)), k = 0..1023, truncated toward zero, two's complement.
  - SIN[0] = 0x0000, SIN[5] = 0x03ED, SIN[10] = 0x07D9, SIN[15] = 0x0BC3, SIN[256] = 0x7FFF, SIN[512] = 0x0000, SIN[768] = 0x8001.
  - Odd symmetry: SIN[k+512] = −SIN[k].
  - Implementation may be a full table or a quarter-wave table plus symmetry logic; output must be bit-exact.
- Output stage: each non-reset edge, dac_signal <= SIN[addr], using the pre-update addr. This is a synchronous table read registered directly into dac_signal.
- Latency: dac_signal after edge n = SIN(phase-after-edge-(n−2)[31:22]). That is 2 clocks from phase to sample, and 3 clocks from a step change to the first affected sample.
- After reset release, sample sequence per edge: SIN(0), SIN(0), SIN((1·step)[31:22]), SIN((2·step)[31:22]), …
- Step changes: a change to freq or freq_add takes effect on the very next edge, with phase continuity and no phase reset.
- step = 0 (including freq_add = −freq): phase holds its value; dac_signal settles to a constant after 2 clocks.
- phase output equals the accumulator register; no extra delay.

Test Plan:
1. Reset: drive reset=1 for 1 edge with arbitrary state -> phase=0x00000000, dac_signal=0x0000 immediately after that edge.
2. 1 MHz at 200 MHz clock: freq=0x0147AEB8, freq_add=0, release reset.
   - phase after edges 1..3 = 0x0147AEB8, 0x028F5D70, 0x03D70C28.
   - dac_signal after edges 1..5 = 0x0000, 0x0000, 0x03ED, 0x07D9, 0x0BC3.
3. Quadrant check: freq=0x40000000, freq_add=0.
   - phase cycles 0x40000000, 0x80000000, 0xC0000000, 0x00000000 (wrap).
   - dac_signal, after 2-cycle lag, repeats 0x7FFF, 0x0000, 0x8001, 0x0000.
4. Signed offset: freq=0x0147AEB8, freq_add=0xFEB85148 (−freq) -> phase stays 0; dac_signal stays 0x0000.
   - Then set freq_add=0x0147AEB8 -> phase steps by 0x028F5D70 per clock starting the next edge.
5. Reset mid-run: run case 2 for 10 clocks, assert reset 1 edge -> phase=0, dac_signal=0.
   - After release, the case-2 sequences repeat exactly.
6. Full-table sweep: freq=0x00400000 (one address per clock) for 1024+2 clocks -> dac_signal walks SIN[0..1023] in order, matching the trunc formula and odd symmetry bit-exactly.
